// File: rtl/sprite_anim_seq.sv
// Sprite animation sequencer: tracks facing direction and animation step, advancing
// the step every HOLD frame ticks in loop or ping-pong order, and forms the sprite ROM index.
module sprite_anim_seq #(
  parameter  int unsigned DIRS    = 4,
  parameter  int unsigned FRAMES  = 4,
  parameter  int unsigned HOLD    = 8,
  parameter  int unsigned DIR_ROT = 1,
  localparam int unsigned DIR_W   = (DIRS > 1) ? $clog2(DIRS) : 1,
  localparam int unsigned STEP_W  = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int unsigned IDX_W   = ((DIRS * FRAMES) > 1) ? $clog2(DIRS * FRAMES) : 1,
  localparam int unsigned HOLD_W  = (HOLD > 1) ? $clog2(HOLD) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_tick,
  input  logic [DIR_W-1:0]  dir,
  input  logic              moving,
  input  logic              mode,
  output logic [IDX_W-1:0]  sprite_idx,
  output logic [STEP_W-1:0] step,
  output logic              step_strobe
);

  localparam int unsigned STEP_LAST = FRAMES - 1;
  localparam int unsigned STEP_PEN  = (FRAMES > 1) ? FRAMES - 2 : 0;
  localparam int unsigned HOLD_LAST = HOLD - 1;
  localparam int unsigned RST_IDX   = ((DIRS - DIR_ROT) % DIRS) * FRAMES;

  logic [DIR_W-1:0]  r_dir;
  logic [STEP_W-1:0] r_step;
  logic [HOLD_W-1:0] r_hold;
  logic              r_up;
  logic [IDX_W-1:0]  r_idx_d;
  logic              r_strobe;

  logic [DIR_W-1:0]  w_dir_n;
  logic [STEP_W-1:0] w_step_n;
  logic [HOLD_W-1:0] w_hold_n;
  logic              w_up_n;
  logic [STEP_W-1:0] w_adv_step;
  logic              w_adv_up;
  logic              w_dir_ok;
  logic [IDX_W-1:0]  w_idx;

  // ROM layout is rotated by DIR_ROT directions relative to the dir encoding
  function automatic logic [IDX_W-1:0] f_idx(input logic [DIR_W-1:0] d,
                                             input logic [STEP_W-1:0] s);
    int unsigned rot;
    rot = (32'(d) + DIRS - DIR_ROT) % DIRS;
    return IDX_W'(rot * FRAMES + 32'(s));
  endfunction

  // Out-of-range directions only exist when DIRS is not a power of two
  if ((1 << DIR_W) == DIRS) begin : g_dir_full
    assign w_dir_ok = 1'b1;
  end else begin : g_dir_partial
    assign w_dir_ok = (32'(dir) < DIRS);
  end

  assign w_idx = f_idx(r_dir, r_step);

  // Step the animation would take on a hold expiry
  always_comb begin
    w_adv_step = r_step;
    w_adv_up   = r_up;
    if (!mode) begin
      w_adv_step = (32'(r_step) == STEP_LAST) ? '0 : r_step + 1'b1;
    end else if (FRAMES > 1) begin
      if (r_up) begin
        if (32'(r_step) == STEP_LAST) begin
          w_adv_up   = 1'b0;
          w_adv_step = STEP_W'(STEP_PEN);
        end else begin
          w_adv_step = r_step + 1'b1;
        end
      end else begin
        if (r_step == '0) begin
          w_adv_up   = 1'b1;
          w_adv_step = STEP_W'(1);
        end else begin
          w_adv_step = r_step - 1'b1;
        end
      end
    end
  end

  // Next state: idle beats direction change beats hold counting
  always_comb begin
    w_dir_n  = r_dir;
    w_step_n = r_step;
    w_hold_n = r_hold;
    w_up_n   = r_up;
    if (!moving) begin
      w_step_n = '0;
      w_hold_n = '0;
      w_up_n   = 1'b1;
      if (frame_tick && w_dir_ok) begin
        w_dir_n = dir;
      end
    end else if (frame_tick) begin
      if (w_dir_ok && (dir != r_dir)) begin
        w_dir_n  = dir;
        w_step_n = '0;
        w_hold_n = '0;
        w_up_n   = 1'b1;
      end else if (32'(r_hold) != HOLD_LAST) begin
        w_hold_n = r_hold + 1'b1;
      end else begin
        w_hold_n = '0;
        w_step_n = w_adv_step;
        w_up_n   = w_adv_up;
      end
    end
  end

  // Strobe compares the index against its one-edge-old copy, so it trails sprite_idx by a cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir    <= '0;
      r_step   <= '0;
      r_hold   <= '0;
      r_up     <= 1'b1;
      r_idx_d  <= IDX_W'(RST_IDX);
      r_strobe <= 1'b0;
    end else begin
      r_dir    <= w_dir_n;
      r_step   <= w_step_n;
      r_hold   <= w_hold_n;
      r_up     <= w_up_n;
      r_idx_d  <= w_idx;
      r_strobe <= (w_idx != r_idx_d);
    end
  end

  assign sprite_idx  = w_idx;
  assign step        = r_step;
  assign step_strobe = r_strobe;

endmodule

// File: tb/tb_sprite_anim_seq.sv
// Directed bench for sprite_anim_seq: three configurations share stimulus, a scoreboard
// holds the expected index/step/strobe for the instance under test in each scenario.
module tb_sprite_anim_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic [1:0] dir;
  logic       moving;
  logic       mode;

  logic [3:0] a_idx, b_idx, c_idx;
  logic [1:0] a_step, b_step;
  logic [2:0] c_step;
  logic       a_stb, b_stb, c_stb;

  always #5 clk = ~clk;

  // a: defaults with HOLD=2; b: defaults with HOLD=1; c: 3 dirs x 5 frames, no rotation
  sprite_anim_seq #(.DIRS(4), .FRAMES(4), .HOLD(2), .DIR_ROT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .dir(dir), .moving(moving),
    .mode(mode), .sprite_idx(a_idx), .step(a_step), .step_strobe(a_stb));

  sprite_anim_seq #(.DIRS(4), .FRAMES(4), .HOLD(1), .DIR_ROT(1)) u_b (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .dir(dir), .moving(moving),
    .mode(mode), .sprite_idx(b_idx), .step(b_step), .step_strobe(b_stb));

  sprite_anim_seq #(.DIRS(3), .FRAMES(5), .HOLD(1), .DIR_ROT(0)) u_c (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .dir(dir), .moving(moving),
    .mode(mode), .sprite_idx(c_idx), .step(c_step), .step_strobe(c_stb));

  typedef struct {
    string tag;
    int    sel;
    int    idx;
    int    stp;
    logic  stb;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   e1;
  int   e2;

  int lp_exp[9] = '{0, 1, 1, 2, 2, 3, 3, 0, 0};
  int pp_exp[9] = '{4, 5, 6, 7, 6, 5, 4, 5, 6};
  int c_exp[6]  = '{10, 11, 12, 13, 14, 10};

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sample(input int sel, output logic [31:0] idx, output logic [31:0] stp,
                        output logic [31:0] stb);
    case (sel)
      0: begin idx = 32'(a_idx); stp = 32'(a_step); stb = 32'(a_stb); end
      1: begin idx = 32'(b_idx); stp = 32'(b_step); stb = 32'(b_stb); end
      default: begin idx = 32'(c_idx); stp = 32'(c_step); stb = 32'(c_stb); end
    endcase
  endtask

  // Expected strobe after edge N reflects a change of the index at edge N-1
  task automatic push(input string tag, input int sel, input int idx, input int frames);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.idx = idx;
    e.stp = idx % frames;
    e.stb = (e1 != e2);
    sb.push_back(e);
    e2 = e1;
    e1 = idx;
  endtask

  task automatic pop_check();
    exp_t        e;
    logic [31:0] oi, os, ob;
    if (sb.size() == 0) begin
      cmp("sb_empty", 32'(1), 32'(0));
    end else begin
      e = sb.pop_front();
      sample(e.sel, oi, os, ob);
      cmp({e.tag, "_idx"}, oi, 32'(e.idx));
      cmp({e.tag, "_step"}, os, 32'(e.stp));
      cmp({e.tag, "_strobe"}, ob, 32'(e.stb));
    end
  endtask

  task automatic cyc(input string tag, input int sel, input logic tk, input logic [1:0] d,
                     input logic mv, input logic md, input int exp_idx, input int frames);
    frame_tick = tk;
    dir        = d;
    moving     = mv;
    mode       = md;
    push(tag, sel, exp_idx, frames);
    @(posedge clk);
    @(negedge clk);
    frame_tick = 1'b0;
    pop_check();
  endtask

  // A frame tick followed by one quiet cycle, so each index change shows its strobe
  task automatic tick(input string tag, input int sel, input logic [1:0] d, input logic mv,
                      input logic md, input int exp_idx, input int frames);
    cyc(tag, sel, 1'b1, d, mv, md, exp_idx, frames);
    cyc({tag, "_q"}, sel, 1'b0, d, mv, md, exp_idx, frames);
  endtask

  task automatic do_reset(input int rst_idx);
    rst_n      = 1'b0;
    frame_tick = 1'b1;
    moving     = 1'b1;
    dir        = 2'd1;
    mode       = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    dir        = 2'd2;
    @(negedge clk);
    cmp("rst_a_idx", 32'(a_idx), 32'(12));
    cmp("rst_a_step", 32'(a_step), 32'(0));
    cmp("rst_a_strobe", 32'(a_stb), 32'(0));
    cmp("rst_b_idx", 32'(b_idx), 32'(12));
    cmp("rst_b_strobe", 32'(b_stb), 32'(0));
    cmp("rst_c_idx", 32'(c_idx), 32'(0));
    cmp("rst_c_strobe", 32'(c_stb), 32'(0));
    frame_tick = 1'b0;
    moving     = 1'b0;
    dir        = 2'd0;
    mode       = 1'b0;
    rst_n      = 1'b1;
    e1         = rst_idx;
    e2         = rst_idx;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

  initial begin
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    dir        = 2'd0;
    moving     = 1'b0;
    mode       = 1'b0;
    @(negedge clk);

    // Loop order with HOLD=2; direction set while idle, then a restart mid-hold
    do_reset(12);
    tick("lp_set", 0, 2'd1, 1'b0, 1'b0, 0, 4);
    for (int i = 0; i < 9; i++) tick($sformatf("lp%0d", i), 0, 2'd1, 1'b1, 1'b0, lp_exp[i], 4);
    tick("hr_restart", 0, 2'd3, 1'b1, 1'b0, 8, 4);
    tick("hr_hold", 0, 2'd3, 1'b1, 1'b0, 8, 4);
    tick("hr_adv", 0, 2'd3, 1'b1, 1'b0, 9, 4);

    // Ping-pong with HOLD=1, then idle drop, direction change and mode switching
    do_reset(12);
    for (int i = 0; i < 9; i++) tick($sformatf("pp%0d", i), 1, 2'd2, 1'b1, 1'b1, pp_exp[i], 4);
    cyc("idle_drop", 1, 1'b0, 2'd2, 1'b0, 1'b1, 4, 4);
    cyc("idle_hold", 1, 1'b0, 2'd2, 1'b0, 1'b1, 4, 4);
    tick("dirchg", 1, 2'd3, 1'b1, 1'b1, 8, 4);
    tick("dirchg_adv", 1, 2'd3, 1'b1, 1'b1, 9, 4);
    tick("ms_loop0", 1, 2'd3, 1'b1, 1'b0, 10, 4);
    tick("ms_pp0", 1, 2'd3, 1'b1, 1'b1, 11, 4);
    tick("ms_pp_turn", 1, 2'd3, 1'b1, 1'b1, 10, 4);
    tick("ms_loop1", 1, 2'd3, 1'b1, 1'b0, 11, 4);
    tick("ms_loop_wrap", 1, 2'd3, 1'b1, 1'b0, 8, 4);
    tick("ms_pp_bottom", 1, 2'd3, 1'b1, 1'b1, 9, 4);

    // Non-power-of-two layout: invalid direction 3 is ignored
    do_reset(0);
    tick("np_set", 2, 2'd2, 1'b1, 1'b0, 10, 5);
    for (int i = 1; i < 6; i++) tick($sformatf("np%0d", i), 2, 2'd2, 1'b1, 1'b0, c_exp[i], 5);
    tick("np_bad0", 2, 2'd3, 1'b1, 1'b0, 11, 5);
    tick("np_bad1", 2, 2'd3, 1'b1, 1'b0, 12, 5);
    tick("np_bad_idle", 2, 2'd3, 1'b0, 1'b0, 10, 5);
    tick("np_idle_dir", 2, 2'd1, 1'b0, 1'b0, 5, 5);
    tick("np_resume", 2, 2'd1, 1'b1, 1'b0, 6, 5);

    // Asynchronous reset between edges while a strobe is pending
    do_reset(12);
    tick("ar_set", 0, 2'd1, 1'b0, 1'b0, 0, 4);
    tick("ar0", 0, 2'd1, 1'b1, 1'b0, 0, 4);
    tick("ar1", 0, 2'd1, 1'b1, 1'b0, 1, 4);
    tick("ar2", 0, 2'd1, 1'b1, 1'b0, 1, 4);
    cyc("ar3", 0, 1'b1, 2'd1, 1'b1, 1'b0, 2, 4);
    #1;
    rst_n = 1'b0;
    #1;
    cmp("ar_async_idx", 32'(a_idx), 32'(12));
    cmp("ar_async_step", 32'(a_step), 32'(0));
    cmp("ar_async_strobe", 32'(a_stb), 32'(0));
    @(posedge clk);
    @(negedge clk);
    cmp("ar_held_strobe", 32'(a_stb), 32'(0));
    cmp("ar_held_idx", 32'(a_idx), 32'(12));
    rst_n = 1'b1;
    e1    = 12;
    e2    = 12;
    tick("ar_release", 0, 2'd1, 1'b1, 1'b0, 0, 4);

    cmp("sb_drained", 32'(sb.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
